tube_display_arbiter: RTL and testbench
=======================================

// Module: tube_display_arbiter
// PURPOSE
//   Shares the single 4-digit seven-segment tube between NREQ requesters (CPU MMIO value, switch echo, timer, ...).
//   Round-robin time-slicing: each granted requester owns the tube for DWELL clocks, then the next requester takes over.
//   Output tube_data feeds the tube driver's 16-bit data input; gnt tells each requester when it is on screen.
// PARAMETERS
//   NREQ   4           number of requesters (2..8)
//   DW     16          display word width (4 hex digits)
//   DWELL  25_000_000  clocks per time slice (>=2); counter width = $clog2(DWELL)
// PORTS
//   clk        in   1        system clock
//   rstn       in   1        synchronous, active-low reset
//   req        in   NREQ     req[i]=1: requester i wants the display
//   data       in   NREQ*DW  data[i*DW +: DW] = value of requester i
//   lock       in   1        1: current owner keeps the tube past DWELL
//   gnt        out  NREQ     one-hot owner, all-zero when idle
//   owner_idx  out  3        index of current owner (0 when idle)
//   tube_data  out  DW       word to display (registered)
//   tube_blank out  1        1: no owner, tube driver should blank
// BEHAVIOUR
//   - Reset (rstn=0 at posedge): state=IDLE, gnt=0, owner_idx=0, tube_data=0, tube_blank=1,
//     dwell_cnt=0, rr pointer=NREQ-1 (so index 0 wins first). Reset mid-slice aborts immediately.
//   - States: IDLE, SHOW.
//   - IDLE: if |req, pick first set req[] scanning from (ptr+1) mod NREQ upward with wrap;
//     next cycle: SHOW, gnt=onehot(pick), owner_idx=pick, ptr=pick, dwell_cnt=0, tube_blank=0.
//     If no req, stay IDLE, outputs hold reset values.
//   - SHOW: tube_data <= data[owner] every cycle (1-cycle latency, live update).
//     dwell_cnt increments by 1 each cycle.
//   - Owner drops req (req[owner]=0): next cycle re-arbitrate from owner+1.
//     If another req is set, switch to it with dwell_cnt=0; else go IDLE (gnt=0, tube_blank=1, tube_data=0).
//     lock ignored in this case.
//   - Slice end (dwell_cnt==DWELL-1, req[owner]=1):
//     lock=1: stay, dwell_cnt wraps to 0.
//     lock=0: re-arbitrate from owner+1. If only the owner requests, it is re-picked (same gnt, dwell_cnt=0).
//   - Owner drop and slice end in the same cycle: treated as owner drop.
//   - New requests arriving mid-slice never pre-empt; they wait for slice end or owner drop.
//   - Handover: gnt changes and the new owner's data appears on tube_data in the same cycle; no blank gap between owners.
//   - gnt is always one-hot or zero; tube_blank == ~|gnt.
//   - Requesters with req=0 are never granted. Round-robin guarantees each requester a slice within NREQ slices.
// STRUCTURE
//   - Shared package tube_pkg: TUBE_DW=16, TUBE_NREQ=4, state encodings ST_IDLE/ST_SHOW, function onehot(idx).
//   - Sub-module rr_pick (combinational): inputs req[NREQ], base[2:0];
//     outputs idx[2:0] (first set bit scanning from base+1 with wrap), found.
//   - Top: state reg, ptr, dwell_cnt, output regs; no other sub-modules.
// TESTING (bench uses NREQ=4, DWELL=4, DW=16)
//   1. Reset, req=0 for 10 cycles -> gnt=0, tube_blank=1, tube_data=0000 throughout.
//   2. req=0101, data0=1234, data2=ABCD, lock=0 -> gnt=0001 for 4 cycles,
//      then 0100 for 4 cycles, then 0001; tube_data alternates 1234/ABCD.
//   3. Only req[3]=1 -> gnt=1000 held indefinitely, dwell_cnt wraps 0..3, tube_data tracks data3 with 1-cycle delay.
//   4. Owner 0 drops req at dwell_cnt=1 while req[1]=1 -> next cycle gnt=0010, dwell_cnt=0;
//      if no other req -> IDLE, tube_blank=1.
//   5. lock=1 with req=0011, owner 0 -> gnt stays 0001 past 12 cycles;
//      lock=0 -> gnt=0010 at next slice end.
//   6. rstn=0 mid-slice with gnt=0100 -> next cycle all outputs at reset values;
//      after release with req=1111, index 0 granted first.

Source files
------------

// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared constants, FSM states and helpers for the display arbiter
package tube_pkg;

    localparam int TUBE_DW   = 16;
    localparam int TUBE_NREQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } tube_state_e;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/tube_display_arbiter_rr_pick.sv
// rtl/tube_display_arbiter_rr_pick.sv - round-robin picker, first set req after base with wrap
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      base,
    output logic [2:0]      idx,
    output logic            found
);

    // base itself is scanned last, so a lone requester re-picks itself
    always_comb begin
        idx   = 3'd0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int p;
            p = (int'(base) + k) % NREQ;
            if (!found && req[p]) begin
                found = 1'b1;
                idx   = 3'(p);
            end
        end
    end

endmodule

// File: rtl/tube_display_arbiter.sv
// rtl/tube_display_arbiter.sv - time-sliced round-robin sharing of one 4-digit tube
module tube_display_arbiter
    import tube_pkg::*;
#(
    parameter int NREQ  = TUBE_NREQ,
    parameter int DW    = TUBE_DW,
    parameter int DWELL = 25_000_000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data,
    input  logic               lock,
    output logic [NREQ-1:0]    gnt,
    output logic [2:0]         owner_idx,
    output logic [DW-1:0]      tube_data,
    output logic               tube_blank
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    tube_state_e   state;
    logic [2:0]    ptr;
    logic [CW-1:0] dwell_cnt;

    logic [2:0]    pick_idx;
    logic          pick_found;
    logic [7:0]    pick_oh;
    logic [DW-1:0] pick_data;
    logic [DW-1:0] owner_data;
    logic          owner_req;
    logic          need_arb;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .base  (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        pick_oh    = onehot(pick_idx);
        pick_data  = '0;
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == pick_idx) pick_data = data[i*DW +: DW];
            if (gnt[i])            owner_data = data[i*DW +: DW];
        end
        owner_req = |(gnt & req);
        // an owner drop wins over a locked slice end
        need_arb  = (state == ST_IDLE) || !owner_req || ((dwell_cnt == LAST) && !lock);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            owner_idx  <= 3'd0;
            tube_data  <= '0;
            tube_blank <= 1'b1;
            dwell_cnt  <= '0;
            ptr        <= 3'(NREQ - 1);
        end else if (need_arb) begin
            dwell_cnt <= '0;
            if (pick_found) begin
                state      <= ST_SHOW;
                gnt        <= pick_oh[NREQ-1:0];
                owner_idx  <= pick_idx;
                ptr        <= pick_idx;
                tube_data  <= pick_data;
                tube_blank <= 1'b0;
            end else begin
                state      <= ST_IDLE;
                gnt        <= '0;
                owner_idx  <= 3'd0;
                tube_data  <= '0;
                tube_blank <= 1'b1;
            end
        end else begin
            tube_data <= owner_data;
            dwell_cnt <= (dwell_cnt == LAST) ? '0 : dwell_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tube_display_arbiter.sv
// tb/tb_tube_display_arbiter.sv - self-checking bench with a slice-level reference model
module tb_tube_display_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int DWELL = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic               lock = 1'b0;
    logic [DW-1:0]      dv [NREQ];
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    gnt;
    logic [2:0]         owner_idx;
    logic [DW-1:0]      tube_data;
    logic               tube_blank;

    int total = 0;
    int bad   = 0;

    int            m_owner;
    int            m_ptr;
    int            m_cnt;
    logic [DW-1:0] m_td;
    logic [NREQ-1:0] e_gnt;
    logic [2:0]      e_idx;
    logic            e_blank;

    assign data = {dv[3], dv[2], dv[1], dv[0]};

    always #5 clk = ~clk;

    tube_display_arbiter #(.NREQ(NREQ), .DW(DW), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .data       (data),
        .lock       (lock),
        .gnt        (gnt),
        .owner_idx  (owner_idx),
        .tube_data  (tube_data),
        .tube_blank (tube_blank)
    );

    // Reference: owner as an integer (-1 = nobody), slice position, last winner.
    function automatic void model_clock();
        bit arb;
        int nxt;
        if (!rstn) begin
            m_owner = -1; m_ptr = NREQ - 1; m_cnt = 0; m_td = '0;
        end else begin
            arb = (m_owner < 0) || !req[m_owner] || ((m_cnt == DWELL - 1) && !lock);
            if (arb) begin
                nxt = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (nxt < 0 && req[(m_ptr + k) % NREQ]) nxt = (m_ptr + k) % NREQ;
                m_cnt = 0;
                if (nxt >= 0) begin
                    m_owner = nxt; m_ptr = nxt; m_td = dv[nxt];
                end else begin
                    m_owner = -1; m_td = '0;
                end
            end else begin
                m_cnt = (m_cnt + 1) % DWELL;
                m_td  = dv[m_owner];
            end
        end
        e_gnt   = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
        e_idx   = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        e_blank = (m_owner < 0);
    endfunction

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req = '0; lock = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step();
            total++;
            if (gnt !== 4'b0000 || tube_blank !== 1'b1 || tube_data !== 16'h0000 || owner_idx !== 3'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d gnt=%b blank=%b data=%h idx=%0d want 0000/1/0000/0",
                         n, gnt, tube_blank, tube_data, owner_idx);
            end
        end
    endtask

    task automatic test_rr_alternate();
        logic [NREQ-1:0] want;
        do_reset();
        dv[0] = 16'h1234; dv[2] = 16'hABCD; req = 4'b0101;
        for (int n = 1; n <= 20; n++) begin
            step();
            want = (((n - 1) / DWELL) % 2) ? 4'b0100 : 4'b0001;
            total++;
            if (gnt !== want || tube_data !== ((want == 4'b0001) ? 16'h1234 : 16'hABCD) || gnt !== e_gnt) begin
                bad++;
                $display("FAIL rr_alternate cyc=%0d gnt=%b data=%h want gnt=%b model=%b", n, gnt, tube_data, want, e_gnt);
            end
        end
    endtask

    task automatic test_single_wrap();
        logic [DW-1:0] drv;
        do_reset();
        req = 4'b1000;
        for (int n = 0; n < 14; n++) begin
            drv = 16'($urandom);
            dv[3] = drv;
            step();
            total++;
            if (gnt !== 4'b1000 || owner_idx !== 3'd3 || tube_data !== drv || tube_blank !== 1'b0) begin
                bad++;
                $display("FAIL single_hold cyc=%0d gnt=%b idx=%0d data=%h want 1000/3/%h", n, gnt, owner_idx, tube_data, drv);
            end
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        dv[0] = 16'h0A0A; dv[1] = 16'h1B1B; req = 4'b0011;
        step();
        step();
        req = 4'b0010;
        step();
        total++;
        if (gnt !== 4'b0010 || tube_data !== 16'h1B1B || owner_idx !== 3'd1) begin
            bad++;
            $display("FAIL drop_switch gnt=%b data=%h idx=%0d want 0010/1b1b/1", gnt, tube_data, owner_idx);
        end
        req = 4'b0000;
        step();
        total++;
        if (gnt !== 4'b0000 || tube_blank !== 1'b1 || tube_data !== 16'h0000) begin
            bad++;
            $display("FAIL drop_idle gnt=%b blank=%b data=%h want 0000/1/0000", gnt, tube_blank, tube_data);
        end
    endtask

    task automatic test_lock();
        int waited;
        do_reset();
        req = 4'b0011; lock = 1'b1;
        for (int n = 0; n < 14; n++) begin
            step();
            total++;
            if (gnt !== 4'b0001) begin
                bad++;
                $display("FAIL lock_hold cyc=%0d gnt=%b want 0001", n, gnt);
            end
        end
        lock = 1'b0;
        waited = 0;
        while (gnt !== 4'b0010 && waited < 6) begin
            step();
            waited++;
        end
        total++;
        if (gnt !== 4'b0010 || waited != 3 || gnt !== e_gnt) begin
            bad++;
            $display("FAIL lock_release gnt=%b after %0d cycles want 0010 after 3", gnt, waited);
        end
    endtask

    task automatic test_reset_mid_slice();
        do_reset();
        req = 4'b0100;
        step();
        step();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL mid_pre gnt=%b want 0100", gnt);
        end
        rstn = 1'b0;
        step();
        total++;
        if (gnt !== 4'b0000 || tube_blank !== 1'b1 || tube_data !== 16'h0000 || owner_idx !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset gnt=%b blank=%b data=%h idx=%0d want reset values", gnt, tube_blank, tube_data, owner_idx);
        end
        rstn = 1'b1; req = 4'b1111;
        step();
        total++;
        if (gnt !== 4'b0001 || owner_idx !== 3'd0) begin
            bad++;
            $display("FAIL mid_first gnt=%b idx=%0d want 0001/0", gnt, owner_idx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req  = 4'($urandom);
            if ($urandom_range(0, 3) != 0) req = gnt | req;
            lock = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NREQ; i++) dv[i] = 16'($urandom);
            rstn = ($urandom_range(0, 60) != 0);
            step();
            total++;
            if (gnt !== e_gnt || owner_idx !== e_idx || tube_data !== m_td || tube_blank !== e_blank
                || !$onehot0(gnt) || tube_blank !== ~|gnt) begin
                bad++;
                $display("FAIL random cyc=%0d gnt=%b idx=%0d data=%h blank=%b want %b/%0d/%h/%b",
                         n, gnt, owner_idx, tube_data, tube_blank, e_gnt, e_idx, m_td, e_blank);
            end
        end
        rstn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) dv[i] = '0;
        test_reset();
        test_rr_alternate();
        test_single_wrap();
        test_owner_drop();
        test_lock();
        test_reset_mid_slice();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
